// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared definitions for the M-stage bus controller.
//   - Address map bases/limits for DM, TC0, TC1 and IG.
//   - Controller state encoding (2-bit).
//   - Address-error exception codes (AdEL/AdES) and an in-range helper.
package mem_bus_ctrl_pkg;

    localparam logic [31:0] DmBase   = 32'h0000_0000;
    localparam logic [31:0] DmLimit  = 32'h0000_2fff;
    localparam logic [31:0] Tc0Base  = 32'h0000_7f00;
    localparam logic [31:0] Tc0Limit = 32'h0000_7f0b;
    localparam logic [31:0] Tc1Base  = 32'h0000_7f10;
    localparam logic [31:0] Tc1Limit = 32'h0000_7f1b;
    localparam logic [31:0] IgBase   = 32'h0000_7f20;
    localparam logic [31:0] IgLimit  = 32'h0000_7f23;

    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDmWait = 2'd1,
        StDmDone = 2'd2
    } bus_state_e;

    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

    // Exception code the M-stage decoder raises for an unmapped address.
    function automatic logic [4:0] addr_exc_code(input logic is_store);
        return is_store ? ExcAdES : ExcAdEL;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: bundles the load/store request, pipeline-control, DM handshake and
// IO target signals of the M-stage bus controller.
//   master : the controller (consumes req_*/dm_ack/dm_rdata/*_rdata, drives the rest)
//   slave  : the surrounding pipeline and targets
interface mem_bus_ctrl_if;

    // M-stage request
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_byteen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_abort;
    // pipeline control / result
    logic        stall_m;
    logic [31:0] rdata;
    logic        bus_err;
    // DM handshake
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    // IO targets
    logic        tc0_we;
    logic        tc1_we;
    logic [3:0]  ig_byteen;
    logic [31:0] tc0_rdata;
    logic [31:0] tc1_rdata;
    logic [31:0] ig_rdata;

    modport master (
        input  req_valid, req_we, req_byteen, req_addr, req_wdata, req_abort,
        input  dm_ack, dm_rdata, tc0_rdata, tc1_rdata, ig_rdata,
        output stall_m, rdata, bus_err,
        output dm_req, dm_we, dm_addr, dm_byteen, dm_wdata,
        output tc0_we, tc1_we, ig_byteen
    );

    modport slave (
        output req_valid, req_we, req_byteen, req_addr, req_wdata, req_abort,
        output dm_ack, dm_rdata, tc0_rdata, tc1_rdata, ig_rdata,
        input  stall_m, rdata, bus_err,
        input  dm_req, dm_we, dm_addr, dm_byteen, dm_wdata,
        input  tc0_we, tc1_we, ig_byteen
    );

endinterface

// File: rtl/mem_bus_ctrl_addr_decode.sv
// mem_bus_ctrl_addr_decode: purely combinational target decode, shared with the M-stage
// decoder. Hits are mutually exclusive; an address outside every window hits nothing.
//   addr     in  32  effective address
//   hit_dm   out 1   0x0000-0x2fff
//   hit_tc0  out 1   0x7f00-0x7f0b
//   hit_tc1  out 1   0x7f10-0x7f1b
//   hit_ig   out 1   0x7f20-0x7f23
module mem_bus_ctrl_addr_decode
    import mem_bus_ctrl_pkg::*;
(
    input  logic [31:0] addr,
    output logic        hit_dm,
    output logic        hit_tc0,
    output logic        hit_tc1,
    output logic        hit_ig
);

    assign hit_dm  = in_range(addr, DmBase, DmLimit);
    assign hit_tc0 = in_range(addr, Tc0Base, Tc0Limit);
    assign hit_tc1 = in_range(addr, Tc1Base, Tc1Limit);
    assign hit_ig  = in_range(addr, IgBase, IgLimit);

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: M-stage bus controller between the load/store path and memory-mapped targets.
// IO targets (TC0/TC1/IG) complete in zero wait states; DM accesses run a latched
// request/ack handshake that stalls the pipeline, guarded by a watchdog that ends a
// silent access with a one-cycle bus_err.
//   clk    in  system clock
//   reset  in  asynchronous, active-low
//   bus    mem_bus_ctrl_if.master: req_*, stall_m, rdata, bus_err, dm_*, tc*_we/rdata, ig_*
// Parameter TIMEOUT: maximum DM_WAIT cycles before bus_err.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input logic            clk,
    input logic            reset,
    mem_bus_ctrl_if.master bus
);

    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    logic hit_dm, hit_tc0, hit_tc1, hit_ig;

    mem_bus_ctrl_addr_decode u_addr_decode (
        .addr    (bus.req_addr),
        .hit_dm  (hit_dm),
        .hit_tc0 (hit_tc0),
        .hit_tc1 (hit_tc1),
        .hit_ig  (hit_ig)
    );

    bus_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          dm_req_q, dm_req_d;
    logic          dm_we_q, dm_we_d;
    logic [31:0]   dm_addr_q, dm_addr_d;
    logic [3:0]    dm_byteen_q, dm_byteen_d;
    logic [31:0]   dm_wdata_q, dm_wdata_d;

    logic issue;
    logic timeout;

    // Gating with reset keeps every output quiet while reset is asserted, even though the
    // request inputs may still be live.
    assign issue   = reset & bus.req_valid & ~bus.req_abort & (state_q == StIdle);
    assign timeout = (state_q == StDmWait) & ~bus.dm_ack & (cnt_q == CntLast);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        dm_req_d      = dm_req_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_byteen_d   = dm_byteen_q;
        dm_wdata_d    = dm_wdata_q;
        bus.stall_m   = 1'b0;
        bus.bus_err   = 1'b0;
        bus.rdata     = '0;
        bus.tc0_we    = 1'b0;
        bus.tc1_we    = 1'b0;
        bus.ig_byteen = '0;

        unique case (state_q)
            StIdle: begin
                bus.tc0_we    = issue & bus.req_we & hit_tc0;
                bus.tc1_we    = issue & bus.req_we & hit_tc1;
                bus.ig_byteen = (issue & hit_ig) ? bus.req_byteen : 4'b0000;

                if (reset) begin
                    if (hit_tc0) begin
                        bus.rdata = bus.tc0_rdata;
                    end else if (hit_tc1) begin
                        bus.rdata = bus.tc1_rdata;
                    end else if (hit_ig) begin
                        bus.rdata = bus.ig_rdata;
                    end
                end

                if (issue && hit_dm) begin
                    bus.stall_m = 1'b1;
                    dm_req_d    = 1'b1;
                    dm_we_d     = bus.req_we;
                    dm_addr_d   = bus.req_addr;
                    dm_byteen_d = bus.req_byteen;
                    dm_wdata_d  = bus.req_wdata;
                    cnt_d       = '0;
                    state_d     = StDmWait;
                end
            end

            StDmWait: begin
                bus.stall_m = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                // An ack arriving in the last watchdog cycle still completes normally.
                if (bus.dm_ack) begin
                    rdata_d  = bus.dm_rdata;
                    dm_req_d = 1'b0;
                    state_d  = StDmDone;
                end else if (timeout) begin
                    bus.bus_err = 1'b1;
                    rdata_d     = '0;
                    dm_req_d    = 1'b0;
                    state_d     = StDmDone;
                end
            end

            // Same instruction is still in M here, so no new issue is allowed.
            StDmDone: begin
                bus.rdata = rdata_q;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rdata_q     <= '0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_byteen_q <= '0;
            dm_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_byteen_q <= dm_byteen_d;
            dm_wdata_q  <= dm_wdata_d;
        end
    end

    assign bus.dm_req    = dm_req_q;
    assign bus.dm_we     = dm_we_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_byteen = dm_byteen_q;
    assign bus.dm_wdata  = dm_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed, self-checking bench for mem_bus_ctrl (TIMEOUT = 16).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl #(
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd, input logic ab);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_byteen = be;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_abort  = ab;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset         = 1'b0;
        bus.dm_ack    = 1'b0;
        bus.dm_rdata  = '0;
        bus.tc0_rdata = 32'h0000_7c00;
        bus.tc1_rdata = 32'h0000_0055;
        bus.ig_rdata  = 32'h0000_00a5;
        // Live request during reset must not leak to any output.
        drive(1'b1, 1'b1, 4'hf, 32'h10, 32'h1234, 1'b0);
        tick();
        tick();
        #1;
        check("rst_stall_m",   32'(bus.stall_m), 32'd0);
        check("rst_bus_err",   32'(bus.bus_err), 32'd0);
        check("rst_rdata",     bus.rdata, 32'd0);
        check("rst_dm_req",    32'(bus.dm_req), 32'd0);
        check("rst_dm_we",     32'(bus.dm_we), 32'd0);
        check("rst_dm_addr",   bus.dm_addr, 32'd0);
        check("rst_dm_byteen", 32'(bus.dm_byteen), 32'd0);
        check("rst_dm_wdata",  bus.dm_wdata, 32'd0);
        check("rst_tc0_we",    32'(bus.tc0_we), 32'd0);
        check("rst_ig_byteen", 32'(bus.ig_byteen), 32'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;

        // 1: sw 0x1234 -> 0x0010, ack on the 2nd wait cycle
        tick();
        drive(1'b1, 1'b1, 4'hf, 32'h10, 32'h1234, 1'b0);
        #1;
        check("t1_issue_stall", 32'(bus.stall_m), 32'd1);
        tick();
        drive(1'b1, 1'b1, 4'hf, 32'h7f04, 32'hffff, 1'b0);   // must be ignored while stalled
        #1;
        check("t1_w1_stall",     32'(bus.stall_m), 32'd1);
        check("t1_w1_dm_req",    32'(bus.dm_req), 32'd1);
        check("t1_w1_dm_we",     32'(bus.dm_we), 32'd1);
        check("t1_w1_dm_addr",   bus.dm_addr, 32'h10);
        check("t1_w1_dm_byteen", 32'(bus.dm_byteen), 32'hf);
        check("t1_w1_dm_wdata",  bus.dm_wdata, 32'h1234);
        check("t1_w1_tc0_we",    32'(bus.tc0_we), 32'd0);
        tick();
        bus.dm_ack = 1'b1;
        #1;
        check("t1_w2_stall",   32'(bus.stall_m), 32'd1);
        check("t1_w2_bus_err", 32'(bus.bus_err), 32'd0);
        tick();
        bus.dm_ack = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        #1;
        check("t1_done_stall",  32'(bus.stall_m), 32'd0);
        check("t1_done_dm_req", 32'(bus.dm_req), 32'd0);
        tick();

        // 2: lw 0x0010 -> 0xdeadbeef, minimum latency
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        #1;
        check("t2_issue_stall", 32'(bus.stall_m), 32'd1);
        tick();
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'hdead_beef;
        #1;
        check("t2_w_dm_we",  32'(bus.dm_we), 32'd0);
        check("t2_w_dm_req", 32'(bus.dm_req), 32'd1);
        tick();
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = '0;
        drive(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        #1;
        check("t2_done_rdata", bus.rdata, 32'hdead_beef);
        check("t2_done_stall", 32'(bus.stall_m), 32'd0);
        tick();
        #1;
        check("t2_idle_rdata", bus.rdata, 32'd0);

        // 3: IO targets, zero wait
        tick();
        drive(1'b1, 1'b1, 4'hf, 32'h7f04, 32'h1, 1'b0);
        #1;
        check("t3_tc0_we",    32'(bus.tc0_we), 32'd1);
        check("t3_tc0_tc1we", 32'(bus.tc1_we), 32'd0);
        check("t3_tc0_stall", 32'(bus.stall_m), 32'd0);
        tick();
        drive(1'b1, 1'b1, 4'hf, 32'h7f18, 32'h2, 1'b0);
        #1;
        check("t3_tc1_we",     32'(bus.tc1_we), 32'd1);
        check("t3_tc1_tc0we",  32'(bus.tc0_we), 32'd0);
        check("t3_tc1_dm_req", 32'(bus.dm_req), 32'd0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h7f14, 32'h0, 1'b0);
        #1;
        check("t3_lw_tc1_rdata", bus.rdata, 32'h55);
        check("t3_lw_tc1_we",    32'(bus.tc1_we), 32'd0);
        check("t3_lw_tc1_stall", 32'(bus.stall_m), 32'd0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h7f08, 32'h0, 1'b0);
        #1;
        check("t3_lw_tc0_rdata", bus.rdata, 32'h7c00);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h7f20, 32'h0, 1'b0);
        #1;
        check("t3_lw_ig_rdata", bus.rdata, 32'ha5);
        tick();
        drive(1'b1, 1'b1, 4'hf, 32'h7f0c, 32'h3, 1'b0);   // hole just past TC0
        #1;
        check("t3_hole_tc0_we", 32'(bus.tc0_we), 32'd0);
        check("t3_hole_rdata",  bus.rdata, 32'd0);
        check("t3_hole_stall",  32'(bus.stall_m), 32'd0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h3000, 32'h0, 1'b0);   // one past DM
        #1;
        check("t3_dm_end_stall", 32'(bus.stall_m), 32'd0);

        // 4: abort suppresses issue
        tick();
        drive(1'b1, 1'b1, 4'b0100, 32'h7f22, 32'h0, 1'b1);
        #1;
        check("t4_abort_ig_byteen", 32'(bus.ig_byteen), 32'd0);
        check("t4_abort_stall",     32'(bus.stall_m), 32'd0);
        tick();
        drive(1'b1, 1'b1, 4'b0100, 32'h7f22, 32'h0, 1'b0);
        #1;
        check("t4_sb_ig_byteen", 32'(bus.ig_byteen), 32'h4);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
        #1;
        check("t4_abort_dm_stall", 32'(bus.stall_m), 32'd0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        #1;
        check("t4_abort_dm_req", 32'(bus.dm_req), 32'd0);

        // Last DM word, ack one cycle after issue
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h2ffc, 32'h0, 1'b0);
        #1;
        check("t4_dm_last_stall", 32'(bus.stall_m), 32'd1);
        tick();
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'hcafe_f00d;
        #1;
        check("t4_dm_last_addr", bus.dm_addr, 32'h2ffc);
        tick();
        bus.dm_ack = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        #1;
        check("t4_dm_last_rdata", bus.rdata, 32'hcafe_f00d);
        tick();

        // 5: no ack -> bus_err on the 16th wait cycle, rdata cleared
        drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        #1;
        check("t5_issue_stall", 32'(bus.stall_m), 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            #1;
            check($sformatf("t5_w%0d_bus_err", i + 1), 32'(bus.bus_err), (i == 15) ? 32'd1 : 32'd0);
            check($sformatf("t5_w%0d_stall", i + 1), 32'(bus.stall_m), 32'd1);
        end
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        #1;
        check("t5_done_bus_err", 32'(bus.bus_err), 32'd0);
        check("t5_done_rdata",   bus.rdata, 32'd0);
        check("t5_done_stall",   32'(bus.stall_m), 32'd0);
        check("t5_done_dm_req",  32'(bus.dm_req), 32'd0);
        tick();

        // 5b: ack in the timeout cycle wins
        drive(1'b1, 1'b0, 4'h0, 32'h24, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 15) begin
                bus.dm_ack   = 1'b1;
                bus.dm_rdata = 32'h0000_600d;
            end
            #1;
            check($sformatf("t5b_w%0d_bus_err", i + 1), 32'(bus.bus_err), 32'd0);
        end
        tick();
        bus.dm_ack = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h24, 32'h0, 1'b0);
        #1;
        check("t5b_done_rdata", bus.rdata, 32'h600d);
        tick();

        // 6: reset mid-access, then a normal load
        drive(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
        tick();
        #1;
        check("t6_wait_dm_req", 32'(bus.dm_req), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_dm_req", 32'(bus.dm_req), 32'd0);
        check("t6_rst_stall",  32'(bus.stall_m), 32'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
        #1;
        check("t6_reissue_stall", 32'(bus.stall_m), 32'd1);
        tick();
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'h0bad_cafe;
        #1;
        check("t6_reissue_dm_req",  32'(bus.dm_req), 32'd1);
        check("t6_reissue_dm_addr", bus.dm_addr, 32'h30);
        tick();
        bus.dm_ack = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
        #1;
        check("t6_reissue_rdata", bus.rdata, 32'h0bad_cafe);
        check("t6_reissue_stall_done", 32'(bus.stall_m), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
